// File: rtl/carry_chain_pkg.sv
// Shared encodings for the fast-carry slice: CY0 sources, carry-in sources, load FSM states.
package carry_chain_pkg;

  localparam int FIELD_BITS = 4;

  typedef enum logic [2:0] {
    CY0_X0     = 3'd0,
    CY0_X1     = 3'd1,
    CY0_AND    = 3'd2,
    CY0_BYPASS = 3'd3,
    CY0_ZERO   = 3'd4,
    CY0_ONE    = 3'd5
  } cy0_sel_e;

  typedef enum logic [1:0] {
    CIN_CARRY     = 2'd0,
    CIN_ZERO      = 2'd1,
    CIN_ONE       = 2'd2,
    CIN_CARRY_ALT = 2'd3
  } cin_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/carry_chain_slice_bit.sv
// One carry-chain bit: CY0 source mux, CYO propagate select, carry mux and sum XOR.
module carry_chain_bit
  import carry_chain_pkg::*;
(
  input  logic [2:0] cy0_sel,
  input  logic       cyo_sel,
  input  logic       lut_out,
  input  logic       x0,
  input  logic       x1,
  input  logic       bypass,
  input  logic       carry_in,
  output logic       carry_out,
  output logic       sum_out
);

  logic cy0;
  logic prop;

  // Encodings 6 and 7 are unused and fall through to a constant 0 generate.
  always_comb begin
    cy0 = 1'b0;
    case (cy0_sel_e'(cy0_sel))
      CY0_X0:     cy0 = x0;
      CY0_X1:     cy0 = x1;
      CY0_AND:    cy0 = x0 & x1;
      CY0_BYPASS: cy0 = bypass;
      CY0_ONE:    cy0 = 1'b1;
      default:    cy0 = 1'b0;
    endcase
  end

  assign prop      = cyo_sel ? lut_out : 1'b1;
  assign carry_out = prop ? carry_in : cy0;
  assign sum_out   = lut_out ^ carry_in;

endmodule

// File: rtl/carry_chain_slice.sv
// Runtime-configurable fast-carry slice with a daisy-chained serial config register.
// Define CARRY_SLICE_REG_OUT_EN to register sum_out/carry_out behind ce.
module carry_chain_slice
  import carry_chain_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_din,
  output logic             cfg_dout,
  output logic             cfg_valid,
  output logic             cfg_err,
  input  logic             ce,
  input  logic [WIDTH-1:0] lut_out,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] bypass,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CFG_BITS = FIELD_BITS * WIDTH + 2;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e               state, state_nxt;
  logic [CFG_BITS-1:0]  cfg_sr;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 cfg_err_nxt;
  logic                 active;
  logic                 chain_cin;
  logic [WIDTH:0]       carry;
  logic [WIDTH-1:0]     sum_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      cfg_err <= 1'b0;
      cfg_sr  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cfg_err <= cfg_err_nxt;
      if (cfg_en)
        cfg_sr <= {cfg_sr[CFG_BITS-2:0], cfg_din};
    end
  end

  // The counter saturates so an over-shift still completes the load cleanly.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cfg_err_nxt = cfg_err;
    case (state)
      ST_IDLE, ST_ACTIVE: begin
        if (cfg_en) begin
          state_nxt   = ST_LOAD;
          bit_cnt_nxt = CNT_ONE;
          cfg_err_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cfg_en) begin
          if (bit_cnt != CNT_FULL)
            bit_cnt_nxt = bit_cnt + CNT_ONE;
        end else if (bit_cnt == CNT_FULL) begin
          state_nxt = ST_ACTIVE;
        end else begin
          state_nxt   = ST_IDLE;
          cfg_err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign active    = (state == ST_ACTIVE);
  assign cfg_valid = active;
  assign cfg_dout  = cfg_sr[CFG_BITS-1];

  always_comb begin
    chain_cin = carry_in;
    case (cin_sel_e'(cfg_sr[CFG_BITS-1 -: 2]))
      CIN_ZERO: chain_cin = 1'b0;
      CIN_ONE:  chain_cin = 1'b1;
      default:  chain_cin = carry_in;
    endcase
  end

  assign carry[0] = chain_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    carry_chain_bit u_bit (
      .cy0_sel   (cfg_sr[FIELD_BITS*i +: 3]),
      .cyo_sel   (cfg_sr[FIELD_BITS*i + 3]),
      .lut_out   (lut_out[i]),
      .x0        (x0[i]),
      .x1        (x1[i]),
      .bypass    (bypass[i]),
      .carry_in  (carry[i]),
      .carry_out (carry[i+1]),
      .sum_out   (sum_raw[i])
    );
  end

`ifdef CARRY_SLICE_REG_OUT_EN
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Leaving ACTIVE clears the register regardless of ce so outputs never leak mid-load.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (ce) begin
      sum_q   <= sum_raw;
      carry_q <= carry[WIDTH];
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = carry_q;
`else
  logic ce_unused;
  assign ce_unused = ce;
  assign sum_out   = active ? sum_raw : '0;
  assign carry_out = active & carry[WIDTH];
`endif

endmodule

// File: tb/tb_carry_chain_slice.sv
// Self-checking bench for carry_chain_slice: directed tables, multi-cycle sequences and
// randomized loads against a queue-based reference model (also covers CARRY_SLICE_REG_OUT_EN).
module tb_carry_chain_slice;

  localparam int WIDTH    = 4;
  localparam int CFG_BITS = 4 * WIDTH + 2;

  localparam logic [CFG_BITS-1:0] ADDER_CFG = 18'h08888;
  localparam logic [CFG_BITS-1:0] PASS_CFG  = 18'h20000;
  localparam logic [CFG_BITS-1:0] OVER_CFG  = 18'h14444;

  logic             clk = 1'b0;
  logic             rst_n, cfg_en, cfg_din, ce, carry_in;
  logic [WIDTH-1:0] lut_out, x0, x1, bypass;
  logic             cfg_dout, cfg_valid, cfg_err, carry_out;
  logic [WIDTH-1:0] sum_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: shift window (index 0 = oldest = MSB), run length of cfg_en.
  logic             m_q[$];
  int               m_run;
  logic             m_active, m_err;
  logic [WIDTH-1:0] m_sum_q;
  logic             m_cout_q;

  typedef struct {
    logic [WIDTH-1:0] lut;
    logic [WIDTH-1:0] a;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t adder_vecs[5];

  carry_chain_slice #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err),
    .ce        (ce),
    .lut_out   (lut_out),
    .x0        (x0),
    .x1        (x1),
    .bypass    (bypass),
    .carry_in  (carry_in),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CFG_BITS-1:0] model_cfg();
    logic [CFG_BITS-1:0] w;
    w = '0;
    for (int k = 0; k < CFG_BITS; k++) w[CFG_BITS-1-k] = m_q[k];
    return w;
  endfunction

  // Returns {carry_out, sum}: a killed bit (cyo=1, lut=0) takes its generate value, others pass carry.
  function automatic logic [WIDTH:0] ref_slice(input logic [CFG_BITS-1:0] cfg,
                                               input logic [WIDTH-1:0] lut, a0, a1, byp,
                                               input logic cin);
    logic             c, g;
    logic [WIDTH-1:0] s;
    logic [2:0]       sel;
    logic [1:0]       csel;
    csel = cfg[CFG_BITS-1 -: 2];
    c = (csel == 2'd1) ? 1'b0 : (csel == 2'd2) ? 1'b1 : cin;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel = cfg[4*i +: 3];
      case (sel)
        3'd0:    g = a0[i];
        3'd1:    g = a1[i];
        3'd2:    g = a0[i] & a1[i];
        3'd3:    g = byp[i];
        3'd5:    g = 1'b1;
        default: g = 1'b0;
      endcase
      s[i] = lut[i] ^ c;
      if (cfg[4*i+3] && !lut[i]) c = g;
    end
    return {c, s};
  endfunction

  function automatic logic [WIDTH:0] model_comb();
    return m_active ? ref_slice(model_cfg(), lut_out, x0, x1, bypass, carry_in) : '0;
  endfunction

  task automatic model_reset();
    m_q = {};
    for (int k = 0; k < CFG_BITS; k++) m_q.push_back(1'b0);
    m_run = 0; m_active = 1'b0; m_err = 1'b0;
    m_sum_q = '0; m_cout_q = 1'b0;
  endtask

  task automatic tick();
    logic [WIDTH:0] r;
    r = model_comb();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_active) begin
        m_sum_q = '0; m_cout_q = 1'b0;
      end else if (ce) begin
        m_sum_q = r[WIDTH-1:0]; m_cout_q = r[WIDTH];
      end
      if (cfg_en) begin
        m_q.push_back(cfg_din);
        void'(m_q.pop_front());
        if (m_run == 0) m_err = 1'b0;
        m_run++;
        m_active = 1'b0;
      end else if (m_run > 0) begin
        m_active = (m_run >= CFG_BITS);
        m_err    = !m_active;
        m_run    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
`ifdef CARRY_SLICE_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_output(input string name);
    logic [WIDTH:0] r;
`ifdef CARRY_SLICE_REG_OUT_EN
    r = {m_cout_q, m_sum_q};
`else
    r = model_comb();
`endif
    compare({name, ".cfg_valid"}, 32'(cfg_valid), 32'(m_active));
    compare({name, ".cfg_err"},   32'(cfg_err),   32'(m_err));
    compare({name, ".cfg_dout"},  32'(cfg_dout),  32'(m_q[0]));
    compare({name, ".sum_out"},   32'(sum_out),   32'(r[WIDTH-1:0]));
    compare({name, ".carry_out"}, 32'(carry_out), 32'(r[WIDTH]));
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] lut, a0, a1, byp, input logic cin);
    lut_out = lut; x0 = a0; x1 = a1; bypass = byp; carry_in = cin;
    settle();
  endtask

  task automatic randomize_inputs();
    lut_out = WIDTH'($urandom); x0 = WIDTH'($urandom); x1 = WIDTH'($urandom);
    bypass = WIDTH'($urandom); carry_in = 1'($urandom);
  endtask

  task automatic shift_bits(input logic [CFG_BITS-1:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      cfg_en = 1'b1; cfg_din = word[i];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic load_and_finish(input logic [CFG_BITS-1:0] word, input string name);
    shift_bits(word, CFG_BITS);
    check_output({name, ".load_end"});
    tick();
    compare({name, ".valid_rise"}, 32'(cfg_valid), 32'd1);
  endtask

  initial begin
    adder_vecs[0] = '{lut: 4'b0110, a: 4'b0111, cin: 1'b0, exp_sum: 4'b1000, exp_cout: 1'b0};
    adder_vecs[1] = '{lut: 4'b1110, a: 4'b1111, cin: 1'b0, exp_sum: 4'b0000, exp_cout: 1'b1};
    adder_vecs[2] = '{lut: 4'b0110, a: 4'b0011, cin: 1'b0, exp_sum: 4'b1000, exp_cout: 1'b0};
    adder_vecs[3] = '{lut: 4'b0000, a: 4'b1000, cin: 1'b1, exp_sum: 4'b0001, exp_cout: 1'b1};
    adder_vecs[4] = '{lut: 4'b0000, a: 4'b0101, cin: 1'b1, exp_sum: 4'b1011, exp_cout: 1'b0};

    rst_n = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; ce = 1'b1;
    lut_out = '0; x0 = '0; x1 = '0; bypass = '0; carry_in = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    randomize_inputs();
    settle();
    check_output("reset");

    // Adder configuration against hand-computed sums.
    load_and_finish(ADDER_CFG, "adder");
    for (int v = 0; v < 5; v++) begin
      apply_stimulus(adder_vecs[v].lut, adder_vecs[v].a, WIDTH'($urandom), WIDTH'($urandom),
                     adder_vecs[v].cin);
      compare($sformatf("adder_vec%0d.sum", v), 32'(sum_out), 32'(adder_vecs[v].exp_sum));
      compare($sformatf("adder_vec%0d.cout", v), 32'(carry_out), 32'(adder_vecs[v].exp_cout));
    end

    load_and_finish(PASS_CFG, "pass");
    apply_stimulus(4'b1010, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    compare("pass.sum", 32'(sum_out), 32'(4'b0101));
    compare("pass.cout", 32'(carry_out), 32'd1);

    // Short load leaves the slice idle with the error flag set.
    shift_bits(CFG_BITS'($urandom), 10);
    tick();
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      lut_out = 4'b1111;
      settle();
      compare("short.err", 32'(cfg_err), 32'd1);
      compare("short.valid", 32'(cfg_valid), 32'd0);
      compare("short.sum", 32'(sum_out), 32'd0);
      check_output("short");
    end

    // Continuous 38-bit shift: adder word then 2 filler bits and the override word.
    for (int n = 0; n < CFG_BITS + 20; n++) begin
      cfg_en = 1'b1;
      if (n < CFG_BITS) cfg_din = ADDER_CFG[CFG_BITS-1-n];
      else if (n < CFG_BITS + 2) cfg_din = 1'b1;
      else cfg_din = OVER_CFG[CFG_BITS-1-(n-CFG_BITS-2)];
      tick();
      randomize_inputs();
      #1;
      compare("over.load_sum", 32'(sum_out), 32'd0);
      compare("over.load_cout", 32'(carry_out), 32'd0);
      if (n >= CFG_BITS - 1 && n < 2 * CFG_BITS - 1)
        compare($sformatf("over.dout%0d", n), 32'(cfg_dout),
                32'(ADDER_CFG[CFG_BITS-1-(n+1-CFG_BITS)]));
      check_output("over.load");
    end
    cfg_en = 1'b0;
    tick();
    compare("over.valid", 32'(cfg_valid), 32'd1);
    apply_stimulus(4'b0110, 4'b1111, 4'b1111, 4'b1111, 1'b1);
    compare("over.cout", 32'(carry_out), 32'd0);
    compare("over.sum", 32'(sum_out), 32'(4'b0110));

    // Reset at bit 9 of a load must discard the partial shift.
    shift_bits(18'h3FFFF, 8);
    cfg_en = 1'b1; cfg_din = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; cfg_en = 1'b0;
    #1;
    compare("midrst.dout", 32'(cfg_dout), 32'd0);
    compare("midrst.err", 32'(cfg_err), 32'd0);
    compare("midrst.valid", 32'(cfg_valid), 32'd0);
    for (int k = 0; k < CFG_BITS - 1; k++) begin
      cfg_en = 1'b1; cfg_din = 1'b0;
      tick();
      compare("midrst.flush_dout", 32'(cfg_dout), 32'd0);
    end
    cfg_en = 1'b0;
    tick();
    check_output("midrst.short");

`ifdef CARRY_SLICE_REG_OUT_EN
    load_and_finish(ADDER_CFG, "reg");
    ce = 1'b1;
    lut_out = 4'b1110; x0 = 4'b1111; carry_in = 1'b0;
    #1;
    compare("reg.latency", 32'(carry_out), 32'd0);
    tick();
    compare("reg.cout", 32'(carry_out), 32'd1);
    compare("reg.sum", 32'(sum_out), 32'd0);
    ce = 1'b0;
    lut_out = 4'b0110; x0 = 4'b0111;
    tick();
    compare("reg.hold_cout", 32'(carry_out), 32'd1);
    compare("reg.hold_sum", 32'(sum_out), 32'd0);
    ce = 1'b1;
`endif

    // Randomized loads, occasional short or over-shifted, then random datapath traffic.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        shift_bits(CFG_BITS'($urandom), $urandom_range(1, CFG_BITS - 1));
      end else begin
        shift_bits(CFG_BITS'($urandom), $urandom_range(0, 3));
        shift_bits(CFG_BITS'($urandom), CFG_BITS);
      end
      tick();
      check_output("rand.cfg");
      for (int v = 0; v < 12; v++) begin
        ce = 1'($urandom);
        randomize_inputs();
        settle();
        check_output("rand.vec");
      end
      ce = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
